// File: rtl/sensor_ctrl_if.sv
// Sensor front-end capture handshake: request pulse out, ready strobe and four data bytes back.
interface sensor_ctrl_if;
    logic       sensor_en;
    logic       sensor_ready;
    logic [7:0] sensor_out_0;
    logic [7:0] sensor_out_1;
    logic [7:0] sensor_out_2;
    logic [7:0] sensor_out_3;

    modport master (
        output sensor_en,
        input  sensor_ready,
        input  sensor_out_0,
        input  sensor_out_1,
        input  sensor_out_2,
        input  sensor_out_3
    );

    modport slave (
        input  sensor_en,
        output sensor_ready,
        output sensor_out_0,
        output sensor_out_1,
        output sensor_out_2,
        output sensor_out_3
    );
endinterface

// File: rtl/sensor_ctrl.sv
// Periodic sensor capture controller: requests a sample every PERIOD cycles,
// packs the four returned bytes into a buffer word, flags full and timeouts,
// and exposes a synchronous read port for the CPU-side wrapper.
module sensor_ctrl #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned PERIOD  = 1024,
    parameter int unsigned CNT_W   = 10,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sctrl_en,
    input  logic              sctrl_clear,
    sensor_ctrl_if.master     sbus,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   sample_cnt,
    output logic              sctrl_interrupt,
    output logic              sctrl_err
);

    localparam int unsigned SCNT_W = ADDR_W + 1;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_RDY, WAIT, FULL} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              wr_en;
    logic              err_set;
    logic [ADDR_W-1:0] wr_ptr;
    logic [CNT_W-1:0]  per_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              drop_q;   // enable fell during REQ/WAIT_RDY: skip the rest of the period
    logic [31:0]       mem [DEPTH];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state, buffer write and timeout decisions; clear overrides everything.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (sctrl_en) state_nxt = REQ;
            end
            REQ: begin
                state_nxt = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (sbus.sensor_ready) begin
                    wr_en     = 1'b1;
                    state_nxt = (sample_cnt == SCNT_W'(DEPTH - 1)) ? FULL : WAIT;
                end else if (tmo_cnt >= TMO_W'(TIMEOUT)) begin
                    err_set   = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (drop_q)                                state_nxt = IDLE;
                else if (per_cnt >= CNT_W'(PERIOD - 1))    state_nxt = sctrl_en ? REQ : IDLE;
            end
            FULL: begin
                state_nxt = FULL;
            end
            default: state_nxt = IDLE;
        endcase
        if (sctrl_clear) begin
            state_nxt = IDLE;
            wr_en     = 1'b0;
            err_set   = 1'b0;
        end
    end

    // Registered outputs, counters and read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            sbus.sensor_en  <= 1'b0;
            rd_valid        <= 1'b0;
            rd_data         <= '0;
            sample_cnt      <= '0;
            sctrl_interrupt <= 1'b0;
            sctrl_err       <= 1'b0;
            wr_ptr          <= '0;
            per_cnt         <= '0;
            tmo_cnt         <= '0;
            drop_q          <= 1'b0;
        end else begin
            sbus.sensor_en  <= (state_nxt == REQ);
            sctrl_interrupt <= (state_nxt == FULL);
            rd_valid        <= rd_en;
            rd_data         <= (rd_en && ({1'b0, rd_addr} < sample_cnt)) ? mem[rd_addr] : '0;

            if (state_nxt == REQ) begin
                per_cnt <= '0;
                tmo_cnt <= '0;
                drop_q  <= 1'b0;
            end else begin
                if ((state == REQ || state == WAIT_RDY || state == WAIT) &&
                    (per_cnt < CNT_W'(PERIOD - 1)))
                    per_cnt <= per_cnt + CNT_W'(1);
                if ((state == REQ || state == WAIT_RDY) && (tmo_cnt < TMO_W'(TIMEOUT)))
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                if ((state == REQ || state == WAIT_RDY) && !sctrl_en)
                    drop_q <= 1'b1;
            end

            if (sctrl_clear) begin
                wr_ptr     <= '0;
                sample_cnt <= '0;
                sctrl_err  <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr     <= wr_ptr + ADDR_W'(1);
                    sample_cnt <= sample_cnt + SCNT_W'(1);
                end
                if (err_set) sctrl_err <= 1'b1;
            end
        end
    end

    // Sample buffer storage; contents survive reset and clear.
    always_ff @(posedge clk) begin
        if (wr_en && !rst)
            mem[wr_ptr] <= {sbus.sensor_out_3, sbus.sensor_out_2,
                            sbus.sensor_out_1, sbus.sensor_out_0};
    end

endmodule
